// File: rtl/interfaz_adc_spi.sv
// -----------------------------------------------------------------------------
// interfaz_adc_spi
//
// Acquisition front end for the 200 Hz low-pass filter. A free-running
// sample-rate counter paces conversions. On each enabled tick the block reads
// one 12-bit result from a serial ADC over a 16-clock, CS_n-framed, MSB-first
// transfer. It converts the offset-binary code to signed Q(N-F).F and presents
// it on Uk with a one-cycle Bandera_ADC strobe. A sample that the filter has
// not yet acknowledged through Bandera_Listo raises the sticky Sobrecarga flag
// when the next sample arrives.
//
// Ports:
//   Clk           in   1  system clock, all logic on the rising edge
//   Reset         in   1  synchronous, active-high
//   Habilitar     in   1  1 lets sample ticks start conversions
//   SDATA         in   1  ADC serial data
//   SCLK          out  1  ADC serial clock, idles high
//   CS_n          out  1  ADC chip select, active low
//   Bandera_Listo in   1  filter done pulse, acknowledges the last sample
//   Uk            out  N  signed sample, held until the next update
//   Bandera_ADC   out  1  one-cycle pulse: Uk has just been updated
//   Sobrecarga    out  1  sticky overrun flag, cleared only by Reset
//
// Configuration macro: RAMPA_PRUEBA_EN
//   When defined, an internal 12-bit ramp replaces the SPI data path. The ramp
//   starts at 0 and steps by one per delivered sample. SCLK and CS_n stay high
//   and SDATA is ignored. Timing and flags are unchanged.
// -----------------------------------------------------------------------------
module interfaz_adc_spi #(
  parameter int N             = 25,
  parameter int F             = 16,
  parameter int DIV           = 4,
  parameter int SAMPLE_PERIOD = 10000
) (
  input  logic                Clk,
  input  logic                Reset,
  input  logic                Habilitar,
  input  logic                SDATA,
  output logic                SCLK,
  output logic                CS_n,
  input  logic                Bandera_Listo,
  output logic signed [N-1:0] Uk,
  output logic                Bandera_ADC,
  output logic                Sobrecarga
);

  localparam int TW = (SAMPLE_PERIOD > 1) ? $clog2(SAMPLE_PERIOD) : 1;
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    REPOSO,
    CONVERSION,
    ENTREGA
  } state_t;

  state_t               state_q, state_d;
  logic [TW-1:0]        tick_cnt_q, tick_cnt_d;
  logic [DW-1:0]        div_cnt_q, div_cnt_d;
  logic                 high_q, high_d;
  logic [3:0]           bit_cnt_q, bit_cnt_d;
  logic signed [N-1:0]  uk_q, uk_d;
  logic                 ack_pend_q, ack_pend_d;
  logic                 sobrecarga_q, sobrecarga_d;
`ifdef RAMPA_PRUEBA_EN
  logic [11:0]          ramp_q, ramp_d;
`else
  // Only the last 12 bits shifted in survive, which are exactly the code bits;
  // the four leading bits fall off the top.
  logic [11:0]          shift_q, shift_d;
`endif

  logic                 tick;
  logic                 half_end;
  logic                 entrega;
  logic [11:0]          code;
  logic signed [11:0]   code_signed;
  logic signed [N-1:0]  code_ext;

  // State register: every flop of the block, synchronous reset.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q      <= REPOSO;
      tick_cnt_q   <= '0;
      div_cnt_q    <= '0;
      high_q       <= 1'b0;
      bit_cnt_q    <= '0;
      uk_q         <= '0;
      ack_pend_q   <= 1'b0;
      sobrecarga_q <= 1'b0;
`ifdef RAMPA_PRUEBA_EN
      ramp_q       <= '0;
`else
      shift_q      <= '0;
`endif
    end else begin
      state_q      <= state_d;
      tick_cnt_q   <= tick_cnt_d;
      div_cnt_q    <= div_cnt_d;
      high_q       <= high_d;
      bit_cnt_q    <= bit_cnt_d;
      uk_q         <= uk_d;
      ack_pend_q   <= ack_pend_d;
      sobrecarga_q <= sobrecarga_d;
`ifdef RAMPA_PRUEBA_EN
      ramp_q       <= ramp_d;
`else
      shift_q      <= shift_d;
`endif
    end
  end

  // Next-state logic: tick pacing, SCLK half-period timing, capture,
  // conversion to fixed point and overrun tracking.
  always_comb begin
    state_d      = state_q;
    div_cnt_d    = div_cnt_q;
    high_d       = high_q;
    bit_cnt_d    = bit_cnt_q;
    uk_d         = uk_q;
    ack_pend_d   = ack_pend_q;
    sobrecarga_d = sobrecarga_q;
`ifdef RAMPA_PRUEBA_EN
    ramp_d       = ramp_q;
    code         = ramp_q;
`else
    shift_d      = shift_q;
    code         = shift_q;
`endif

    tick       = (tick_cnt_q == TW'(SAMPLE_PERIOD - 1));
    tick_cnt_d = tick ? '0 : tick_cnt_q + 1'b1;
    half_end   = (div_cnt_q == DW'(DIV - 1));
    entrega    = (state_q == ENTREGA);

    // Offset binary to two's complement is a flip of the top bit. The result
    // is sign-extended and then scaled so the LSB weighs 2^-11.
    code_signed = {~code[11], code[10:0]};
    code_ext    = {{(N-12){code_signed[11]}}, code_signed};

    unique case (state_q)
      REPOSO: begin
        div_cnt_d = '0;
        high_d    = 1'b0;
        bit_cnt_d = '0;
        if (tick && Habilitar) begin
          state_d = CONVERSION;
        end
      end
      CONVERSION: begin
        if (!half_end) begin
          div_cnt_d = div_cnt_q + 1'b1;
        end else begin
          div_cnt_d = '0;
          if (!high_q) begin
            // Last low cycle: this edge is the SCLK rising edge.
            high_d = 1'b1;
`ifndef RAMPA_PRUEBA_EN
            shift_d = {shift_q[10:0], SDATA};
`endif
          end else begin
            high_d = 1'b0;
            if (bit_cnt_q == 4'd15) begin
              state_d = ENTREGA;
              uk_d    = code_ext <<< (F - 11);
`ifdef RAMPA_PRUEBA_EN
              ramp_d  = ramp_q + 12'd1;
`endif
            end else begin
              bit_cnt_d = bit_cnt_q + 4'd1;
            end
          end
        end
      end
      ENTREGA: begin
        state_d = REPOSO;
      end
      default: begin
        state_d = REPOSO;
      end
    endcase

    // A done pulse that lands with the strobe acknowledges the previous sample.
    // The new sample is still left pending.
    if (entrega && ack_pend_q && !Bandera_Listo) begin
      sobrecarga_d = 1'b1;
    end
    if (entrega) begin
      ack_pend_d = 1'b1;
    end else if (Bandera_Listo) begin
      ack_pend_d = 1'b0;
    end
  end

  // Output decode from the registered state.
  always_comb begin
`ifdef RAMPA_PRUEBA_EN
    SCLK = 1'b1;
    CS_n = 1'b1;
`else
    SCLK = !((state_q == CONVERSION) && !high_q);
    CS_n = (state_q != CONVERSION);
`endif
    Bandera_ADC = (state_q == ENTREGA);
    Uk          = uk_q;
    Sobrecarga  = sobrecarga_q;
  end

endmodule
